multi_operand_adder_pipe: RTL and testbench

//  Parametrised successor of the two-operand signed adder: sums N_OPS signed operands.
//  Any operand flagged absent is replaced by a per-operand constant DEFAULT.

---
 rtl/multi_operand_adder_pkg.sv | 14 +
 rtl/multi_operand_adder_pipe_signed_resize.sv | 51 +++++
 rtl/multi_operand_adder_pipe.sv | 113 +++++++++++
 tb/tb_multi_operand_adder_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_operand_adder_pkg.sv
// Shared types and helpers for the multi-operand adder family.
package multi_operand_adder_pkg;

    typedef enum logic {
        RESIZE_WRAP = 1'b0,
        RESIZE_SAT  = 1'b1
    } resize_mode_e;

    // Exact width of a sum of n_ops signed in_w-bit operands.
    function automatic int full_width(input int n_ops, input int in_w);
        return (n_ops <= 1) ? in_w : in_w + $clog2(n_ops);
    endfunction

endpackage

// File: rtl/multi_operand_adder_pipe_signed_resize.sv
// Combinational signed resize from IN_W to OUT_W bits, wrapping or
// saturating, with a flag raised when the value did not fit.
module signed_resize
    import multi_operand_adder_pkg::*;
#(
    parameter int           IN_W  = 8,
    parameter int           OUT_W = 8,
    parameter resize_mode_e MODE  = RESIZE_WRAP
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    generate
        if (OUT_W >= IN_W) begin : g_extend
            // Widening never loses information.
            always_comb begin
                dout = OUT_W'(din);
                ovf  = 1'b0;
            end
        end else if (MODE == RESIZE_WRAP) begin : g_wrap
            logic signed [IN_W-1:0] back;
            // Truncate, then flag when sign-extending back does not restore the input.
            always_comb begin
                dout = din[OUT_W-1:0];
                back = IN_W'(dout);
                ovf  = (back != din);
            end
        end else begin : g_sat
            localparam longint MAX_V = (longint'(1) <<< (OUT_W - 1)) - 1;
            localparam longint MIN_V = -MAX_V - 1;
            logic signed [63:0] wide;
            // Clamp to the OUT_W signed range, flag when clamped.
            always_comb begin
                wide = 64'(din);
                if (wide > MAX_V) begin
                    dout = OUT_W'(MAX_V);
                    ovf  = 1'b1;
                end else if (wide < MIN_V) begin
                    dout = OUT_W'(MIN_V);
                    ovf  = 1'b1;
                end else begin
                    dout = din[OUT_W-1:0];
                    ovf  = 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Two-stage pipelined sum of N_OPS signed operands with per-operand default
// substitution, wrap/saturate resize, valid/ready handshakes and a result counter.
// in_ready depends combinationally on out_ready (no skid buffer); consumers
// must not derive out_ready from in_ready.
module multi_operand_adder_pipe
    import multi_operand_adder_pkg::*;
#(
    parameter int                    N_OPS    = 2,
    parameter int                    IN_W     = 1,
    parameter int                    OUT_W    = IN_W + $clog2(N_OPS),
    parameter int                    SAT_MODE = 0,
    parameter logic [N_OPS*IN_W-1:0] DEFAULTS = '0,
    parameter int                    CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_OPS*IN_W-1:0]   in_data,
    input  logic [N_OPS-1:0]        in_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_sum,
    output logic                    out_ovf,
    output logic [CNT_W-1:0]        txn_count
);

    localparam int           FULL_W = full_width(N_OPS, IN_W);
    localparam resize_mode_e MODE   = (SAT_MODE != 0) ? RESIZE_SAT : RESIZE_WRAP;

    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s1_adv;
    logic                     s2_adv;
    logic signed [FULL_W-1:0] ops_ext [N_OPS];
    logic signed [FULL_W-1:0] s1_ops  [N_OPS];
    logic signed [FULL_W-1:0] sum_full;
    logic signed [OUT_W-1:0]  sum_rs;
    logic                     ovf_rs;

    // Stage advance: a stage moves when empty or when its successor moves.
    always_comb begin
        s2_adv = !s2_valid || out_ready;
        s1_adv = !s1_valid || s2_adv;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Select live or default operand and sign-extend it to the exact sum width.
    always_comb begin
        ops_ext = '{default: '0};
        for (int unsigned i = 0; i < N_OPS; i++) begin
            ops_ext[i] = FULL_W'($signed(in_en[i] ? in_data[i*IN_W +: IN_W]
                                                  : DEFAULTS[i*IN_W +: IN_W]));
        end
    end

    // Stage 1: capture the substituted operand set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ops <= ops_ext;
            end
        end
    end

    // Exact sum of the registered operands; FULL_W cannot overflow.
    always_comb begin
        sum_full = '0;
        for (int unsigned i = 0; i < N_OPS; i++) begin
            sum_full = sum_full + s1_ops[i];
        end
    end

    signed_resize #(
        .IN_W  (FULL_W),
        .OUT_W (OUT_W),
        .MODE  (MODE)
    ) u_resize (
        .din  (sum_full),
        .dout (sum_rs),
        .ovf  (ovf_rs)
    );

    // Stage 2: register the resized result; holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_sum  <= '0;
            out_ovf  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= sum_rs;
                out_ovf <= ovf_rs;
            end
        end
    end

    // Count results taken by the consumer; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (s2_valid && out_ready) begin
            txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Self-checking bench: directed 1-bit tests plus randomized wrap/saturate
// streams compared against a plain-arithmetic reference model.
module tb_multi_operand_adder_pipe;

    localparam logic [31:0] DEFS = 32'h807F05FB; // op3=-128 op2=127 op1=5 op0=-5

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a: N_OPS=2, IN_W=1
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [1:0]        a_data = '0;
    logic [1:0]        a_en = '0;
    logic              a_out_valid;
    logic              a_out_ready = 1'b1;
    logic signed [1:0] a_sum;
    logic              a_ovf;
    logic [15:0]       a_txn;

    // DUTs b (saturate, CNT_W=4) and c (wrap) share inputs
    logic              in_valid = 1'b0;
    logic [31:0]       in_data = '0;
    logic [3:0]        in_en = '0;
    logic              out_ready = 1'b1;
    logic              b_in_ready, c_in_ready;
    logic              b_out_valid, c_out_valid;
    logic signed [7:0] b_sum, c_sum;
    logic              b_ovf, c_ovf;
    logic [3:0]        b_txn;
    logic [15:0]       c_txn;

    multi_operand_adder_pipe #(
        .N_OPS(2), .IN_W(1), .DEFAULTS(2'b10)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_en(a_en), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_sum(a_sum), .out_ovf(a_ovf), .txn_count(a_txn)
    );

    multi_operand_adder_pipe #(
        .N_OPS(4), .IN_W(8), .OUT_W(8), .SAT_MODE(1), .DEFAULTS(DEFS), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_en(in_en), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_sum), .out_ovf(b_ovf), .txn_count(b_txn)
    );

    multi_operand_adder_pipe #(
        .N_OPS(4), .IN_W(8), .OUT_W(8), .SAT_MODE(0), .DEFAULTS(DEFS), .CNT_W(16)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_en(in_en), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_sum(c_sum), .out_ovf(c_ovf), .txn_count(c_txn)
    );

    typedef struct {
        longint sat;
        bit     sat_ovf;
        longint wrp;
        bit     wrp_ovf;
        int     acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;
    int   cyc = 0;
    bit   last_b_rdy;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint full_sum(input logic [31:0] d, input logic [3:0] e);
        longint     s;
        logic [7:0] v;
        logic [31:0] defs;
        s = 0;
        defs = DEFS;
        for (int i = 0; i < 4; i++) begin
            v = e[i] ? d[8*i +: 8] : defs[8*i +: 8];
            s += longint'($signed(v));
        end
        return s;
    endfunction

    function automatic exp_t make_exp(input longint s);
        exp_t   x;
        longint w;
        x.sat     = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        x.sat_ovf = (x.sat != s);
        w = ((s % 256) + 256) % 256;
        if (w > 127) w -= 256;
        x.wrp     = w;
        x.wrp_ovf = (w != s);
        x.acc     = 0;
        return x;
    endfunction

    function automatic logic [31:0] rand_data();
        logic [31:0] d;
        d = $urandom;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
                0: d[8*i +: 8] = 8'h7F;
                1: d[8*i +: 8] = 8'h80;
                default: ;
            endcase
        end
        return d;
    endfunction

    // One cycle on DUTs b/c: drive, sample at negedge, update model, cross the edge.
    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] e,
                        input bit r, output bit acc);
        exp_t x;
        bit   exp_rdy, exp_ov;
        in_valid  = v;
        in_data   = d;
        in_en     = e;
        out_ready = r;
        @(negedge clk);
        last_b_rdy = b_in_ready;
        check("b_txn", b_txn, n_out % 16);
        check("c_txn", c_txn, n_out % 65536);
        exp_rdy = !(q.size() == 2 && !r);
        exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("b_in_ready", b_in_ready, exp_rdy);
        check("c_in_ready", c_in_ready, exp_rdy);
        check("b_out_valid", b_out_valid, exp_ov);
        check("c_out_valid", c_out_valid, exp_ov);
        if (exp_ov) begin
            check("b_sum_sat", b_sum, q[0].sat);
            check("b_ovf_sat", b_ovf, q[0].sat_ovf);
            check("c_sum_wrap", c_sum, q[0].wrp);
            check("c_ovf_wrap", c_ovf, q[0].wrp_ovf);
        end
        if (exp_ov && r) begin
            void'(q.pop_front());
            n_out++;
        end
        acc = v && exp_rdy;
        if (acc) begin
            x = make_exp(full_sum(d, e));
            x.acc = cyc;
            q.push_back(x);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget);
        bit acc;
        for (int i = 0; i < budget && q.size() > 0; i++) step(1'b0, '0, '0, 1'b1, acc);
        check("drain_done", q.size(), 0);
    endtask

    task automatic check_bc_reset(input string tag);
        check({tag, "_b_valid"}, b_out_valid, 0);
        check({tag, "_c_valid"}, c_out_valid, 0);
        check({tag, "_b_sum"}, b_sum, 0);
        check({tag, "_c_ovf"}, c_ovf, 0);
        check({tag, "_b_txn"}, b_txn, 0);
        check({tag, "_c_txn"}, c_txn, 0);
        check({tag, "_b_ready"}, b_in_ready, 1);
    endtask

    // Reset with in_valid held high: nothing may be captured.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = rand_data();
        in_en    = '1;
        a_valid  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        q.delete();
        n_out = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] vd [5];
        logic [1:0] ve [5];
        int         vx [5];
        bit         acc, saw_stall;
        int         sent;

        do_reset();
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_sum", a_sum, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_txn", a_txn, 0);
        check("rst_a_ready", a_ready, 1);
        check_bc_reset("rst");

        // 1-bit operands: full inputs, then default substitution (slice1=-1, slice0=0)
        vd = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b00};
        ve = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
        vx = '{-2, -1, 0, -2, -1};
        for (int k = 0; k <= 6; k++) begin
            if (k < 5) begin
                a_valid = 1'b1;
                a_data  = vd[k];
                a_en    = ve[k];
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
            check("a_in_ready", a_ready, 1);
            @(posedge clk);
            #1;
            if (k >= 1 && k <= 5) begin
                check("a_out_valid", a_out_valid, 1);
                check("a_sum", a_sum, vx[k-1]);
                check("a_ovf", a_ovf, 0);
            end else begin
                check("a_out_valid_idle", a_out_valid, 0);
            end
        end
        check("a_txn", a_txn, 5);

        // Saturate/wrap corner sums: 100+100+100+0 and -128*4
        step(1'b1, {8'd0, 8'd100, 8'd100, 8'd100}, 4'hF, 1'b1, acc);
        step(1'b1, 32'h80808080, 4'hF, 1'b1, acc);
        drain(10);

        // Backpressure: 10 sets, out_ready low in cycles 3..7
        do_reset();
        sent = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 60 && (sent < 10 || q.size() > 0); i++) begin
            step(sent < 10, rand_data(), 4'($urandom), !(i >= 3 && i <= 7), acc);
            if (acc) sent++;
            if (!last_b_rdy) saw_stall = 1'b1;
        end
        check("bp_all_sent", sent, 10);
        check("bp_drained", q.size(), 0);
        check("bp_in_ready_dropped", saw_stall, 1);
        check("bp_b_txn", b_txn, 10);
        check("bp_c_txn", c_txn, 10);

        // Reset with two sets in flight: they must never appear
        step(1'b1, rand_data(), 4'hF, 1'b0, acc);
        step(1'b1, rand_data(), 4'hF, 1'b0, acc);
        check("mid_two_in_flight", q.size(), 2);
        do_reset();
        check_bc_reset("mid_rst");
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, acc);

        // Counter wrap: 17 results on a 4-bit counter
        sent = 0;
        for (int i = 0; i < 40 && sent < 17; i++) begin
            step(1'b1, rand_data(), 4'($urandom), 1'b1, acc);
            if (acc) sent++;
        end
        drain(10);
        check("wrap_b_txn", b_txn, 1);
        check("wrap_c_txn", c_txn, 17);

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, rand_data(), 4'($urandom), ($urandom % 3) != 0, acc);
        end
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
